mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback for each instruction from the 6-bit opcode. Drives datapath enables and muxes, and produces the 2-bit ALU_op consumed by ALU_Control together with FuncCode.

Parameters:
WAIT_EN, 1, 1 = honour mem_ready wait states; 0 = treat mem_ready as always 1.
STATE_W, 4, state register width (12 states used).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
opcode  in  6  instruction[31:26], taken from IR (valid from DECODE onward)
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (gated externally)
i_or_d  out  1  memory address mux: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR
ir_write  out  1  IR load
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ALU_op  out  2  00 = add, 01 = subtract, 10 = use FuncCode; 11 is never driven
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm shifted left 2
reg_write  out  1  register file write
reg_dst  out  1  0 = rt, 1 = rd
illegal_op  out  1  one-cycle pulse on unknown opcode
state_dbg  out  STATE_W  current state encoding

Behaviour:
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000. Any other opcode is illegal.
- Outputs are Moore-decoded from the state, except that ir_write and pc_write in FETCH are qualified by mem_ready. Any output not listed for a state is 0.
- Reset: asynchronous. State = FETCH (0). While reset = 1, pc_write, pc_write_cond, ir_write, reg_write and mem_write are forced to 0, and illegal_op = 0. Reset asserted mid-instruction aborts it; no further writes occur.
- States and assertions:
  - FETCH (0): mem_read, alu_src_b = 01, ALU_op = 00, pc_source = 00. ir_write and pc_write = mem_ready. Stay while !mem_ready; otherwise go to DECODE.
  - DECODE (1): alu_src_b = 11, ALU_op = 00 (branch target into ALUOut). Next state: LW/SW -> MEMADR; R -> RTYPE_EX; BEQ -> BEQ_EX; J -> JUMP_EX; ADDI -> ADDI_EX; illegal -> FETCH with illegal_op = 1 for this cycle.
  - MEMADR (2): alu_src_a = 1, alu_src_b = 10, ALU_op = 00. Next: LW -> MEMREAD, SW -> MEMWRITE.
  - MEMREAD (3): mem_read, i_or_d = 1. Stay until mem_ready, then go to MEMWB.
  - MEMWB (4): reg_write, mem_to_reg = 1, reg_dst = 0. Next: FETCH.
  - MEMWRITE (5): mem_write, i_or_d = 1. Stay until mem_ready, then go to FETCH. mem_write is held high for the whole wait.
  - RTYPE_EX (6): alu_src_a = 1, alu_src_b = 00, ALU_op = 10. Next: RTYPE_WB.
  - RTYPE_WB (7): reg_write, reg_dst = 1, mem_to_reg = 0. Next: FETCH.
  - BEQ_EX (8): alu_src_a = 1, alu_src_b = 00, ALU_op = 01, pc_write_cond, pc_source = 01. Next: FETCH.
  - JUMP_EX (9): pc_write, pc_source = 10. Next: FETCH.
  - ADDI_EX (10): alu_src_a = 1, alu_src_b = 10, ALU_op = 00. Next: ADDI_WB.
  - ADDI_WB (11): reg_write, reg_dst = 0, mem_to_reg = 0. Next: FETCH.
- Unused encodings 12-15 go to FETCH on the next clock, with all outputs 0.
- Cycle counts with mem_ready = 1: LW 5; SW 4; R 4; ADDI 4; BEQ 3; J 3; illegal 2. Each cycle of mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- opcode is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- With WAIT_EN = 0, no state ever holds for a wait.

Test Plan:
- Reset asserted mid-RTYPE_EX, asynchronously -> state_dbg = 0 immediately with no clock edge; all write enables 0 until reset is released; FETCH follows.
- opcode = 000000, mem_ready = 1 -> states 0,1,6,7,0. ALU_op = 00,00,10,xx. reg_write = 1 and reg_dst = 1 only in state 7.
- opcode = 100011, with mem_ready = 0 for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0. mem_read and i_or_d held through state 3. reg_write with mem_to_reg = 1 in state 4.
- opcode = 101011, mem_ready = 0 for 1 cycle in FETCH -> ir_write/pc_write = 0 in the first FETCH cycle and 1 in the second. States 0,0,1,2,5,0.
- BEQ then J back to back -> BEQ: states 0,1,8 with ALU_op = 01, pc_write_cond = 1, pc_source = 01. J: states 0,1,9 with pc_write = 1, pc_source = 10. ALU_op is never 11 in any state.
- opcode = 111111 -> states 0,1,0. illegal_op = 1 for exactly the DECODE cycle. No reg_write or mem_write is asserted.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: control-unit <-> datapath bundle (opcode/mem_ready in, control lines out).
interface mips_multicycle_control_if #(parameter int STATE_W = 4);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               ir_write;
  logic [1:0]         pc_source;
  logic [1:0]         ALU_op;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic               reg_write;
  logic               reg_dst;
  logic               illegal_op;
  logic [STATE_W-1:0] state_dbg;
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
           pc_source, ALU_op, alu_src_a, alu_src_b, reg_write, reg_dst, illegal_op, state_dbg
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
           pc_source, ALU_op, alu_src_a, alu_src_b, reg_write, reg_dst, illegal_op, state_dbg
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main control FSM (fetch/decode/execute/mem/writeback).
module mips_multicycle_control #(
  parameter int WAIT_EN = 1,
  parameter int STATE_W = 4
) (
  input logic clk,
  input logic reset,
  mips_multicycle_control_if.master bus
);
  localparam logic [STATE_W-1:0] FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] RTYPE_EX = STATE_W'(6);
  localparam logic [STATE_W-1:0] RTYPE_WB = STATE_W'(7);
  localparam logic [STATE_W-1:0] BEQ_EX   = STATE_W'(8);
  localparam logic [STATE_W-1:0] JUMP_EX  = STATE_W'(9);
  localparam logic [STATE_W-1:0] ADDI_EX  = STATE_W'(10);
  localparam logic [STATE_W-1:0] ADDI_WB  = STATE_W'(11);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  logic [STATE_W-1:0] state, state_nx;
  logic rdy, legal, pw, pwc, irw, rw, mw, ill;
  assign rdy   = (WAIT_EN != 0) ? bus.mem_ready : 1'b1;
  assign legal = bus.opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx       = FETCH;
    pw             = 1'b0;
    pwc            = 1'b0;
    irw            = 1'b0;
    rw             = 1'b0;
    mw             = 1'b0;
    ill            = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.pc_source  = 2'b00;
    bus.ALU_op     = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.reg_dst    = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        pw            = rdy;
        irw           = rdy;
        state_nx      = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        ill           = !legal;
        state_nx      = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                        (bus.opcode == OP_R)    ? RTYPE_EX :
                        (bus.opcode == OP_BEQ)  ? BEQ_EX   :
                        (bus.opcode == OP_J)    ? JUMP_EX  :
                        (bus.opcode == OP_ADDI) ? ADDI_EX  : FETCH;
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_nx      = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        state_nx     = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        rw             = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        mw         = 1'b1;
        bus.i_or_d = 1'b1;
        state_nx   = rdy ? FETCH : MEMWRITE;
      end
      RTYPE_EX: begin
        bus.alu_src_a = 1'b1;
        bus.ALU_op    = 2'b10;
        state_nx      = RTYPE_WB;
      end
      RTYPE_WB: begin
        rw          = 1'b1;
        bus.reg_dst = 1'b1;
      end
      BEQ_EX: begin
        bus.alu_src_a = 1'b1;
        bus.ALU_op    = 2'b01;
        bus.pc_source = 2'b01;
        pwc           = 1'b1;
      end
      JUMP_EX: begin
        pw            = 1'b1;
        bus.pc_source = 2'b10;
      end
      ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_nx      = ADDI_WB;
      end
      ADDI_WB: rw = 1'b1;
      default: ;
    endcase
  end
  // reset suppresses every side effect even though FETCH still decodes mem_read
  assign bus.pc_write      = pw & ~reset;
  assign bus.pc_write_cond = pwc & ~reset;
  assign bus.ir_write      = irw & ~reset;
  assign bus.reg_write     = rw & ~reset;
  assign bus.mem_write     = mw & ~reset;
  assign bus.illegal_op    = ill & ~reset;
  assign bus.state_dbg     = state;
endmodule
